// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
//   ST_*    : FSM state encodings (IDLE / RUN / DONE)
//   state_t : enum built on those encodings
//   NIB_W   : width of one lookahead step (bits per cycle)
package cla_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/cla4_cell.sv
// Purely combinational 4-bit carry-lookahead adder.
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module cla4_cell (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum-of-products of g/p and cin; no ripple path.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. Operands are latched on an
// in_valid/in_ready handshake, then one nibble per cycle is pushed through a
// single cla4_cell with the inter-nibble carry held in a register. The result
// is presented with out_valid until taken with out_ready.
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid, in_ready  : operand handshake (in_ready = IDLE)
//   a, b, cin, op_sub   : operands; op_sub=1 gives a-b and ignores cin
//   out_valid, out_ready: result handshake
//   sum, cout, overflow : result, carry out (1 = no borrow on subtract),
//                         signed overflow
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SEL_W = $clog2(WIDTH);

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;

  logic [SEL_W-1:0] off;
  logic             last;
  logic [NIB_W-1:0] cell_sum;
  logic             cell_cout;
  logic             msb_new;

  // Bit offset of the current nibble; the cast keeps the select index exactly
  // as wide as the operand needs (matters for WIDTH=4 where idx is a dummy bit).
  assign off  = SEL_W'({idx, 2'b00});
  assign last = (idx == IDX_W'(NIB - 1));

  cla4_cell u_cell (
    .a    (a_q[off +: NIB_W]),
    .b    (b_q[off +: NIB_W]),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // MSB of sum as it will be after this edge; only the top nibble touches it.
  assign msb_new  = last ? cell_sum[NIB_W-1] : sum[WIDTH-1];
  assign in_ready = (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          // Subtract as a + ~b + 1: invert b and force the carry-in.
          a_q   <= a;
          b_q   <= op_sub ? ~b : b;
          carry <= op_sub ? 1'b1 : cin;
          idx   <= '0;
          sum   <= '0;
        end
        S_RUN: begin
          sum[off +: NIB_W] <= cell_sum;
          carry    <= cell_cout;
          cout     <= cell_cout;
          overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (msb_new != a_q[WIDTH-1]);
          idx      <= last ? '0 : idx + 1'b1;
          if (last) out_valid <= 1'b1;
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_t, b_t;
  logic        cin_t, sub_t, ordy;
  logic        iv4, iv16, iv32;
  logic        ir4, ir16, ir32, ov4, ov16, ov32;
  logic        co4, co16, co32, vf4, vf16, vf32;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a_t[3:0]), .b(b_t[3:0]),
    .cin(cin_t), .op_sub(sub_t), .out_valid(ov4), .out_ready(ordy), .sum(s4),
    .cout(co4), .overflow(vf4));
  cla_seq_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a_t[15:0]), .b(b_t[15:0]),
    .cin(cin_t), .op_sub(sub_t), .out_valid(ov16), .out_ready(ordy), .sum(s16),
    .cout(co16), .overflow(vf16));
  cla_seq_adder #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a_t), .b(b_t),
    .cin(cin_t), .op_sub(sub_t), .out_valid(ov32), .out_ready(ordy), .sum(s32),
    .cout(co32), .overflow(vf32));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic set_iv(input int w, input logic v);
    iv4 = (w == 4) ? v : 1'b0;
    iv16 = (w == 16) ? v : 1'b0;
    iv32 = (w == 32) ? v : 1'b0;
  endtask

  task automatic sample(input int w, output logic ov, output logic ir,
                        output logic [31:0] s, output logic co, output logic vf);
    case (w)
      4:       begin ov = ov4;  ir = ir4;  s = {28'd0, s4};  co = co4;  vf = vf4;  end
      16:      begin ov = ov16; ir = ir16; s = {16'd0, s16}; co = co16; vf = vf16; end
      default: begin ov = ov32; ir = ir32; s = s32;          co = co32; vf = vf32; end
    endcase
  endtask

  // One operation: accept, scramble inputs during RUN, measure latency,
  // check result, optionally complete the output handshake.
  task automatic do_op(input string tag, input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub, input int exp_lat,
                       input logic [31:0] es, input logic ec, input logic ev, input logic ack);
    logic ov, ir, co, vf;
    logic [31:0] s;
    int lat;
    a_t = a; b_t = b; cin_t = ci; sub_t = sub;
    set_iv(w, 1'b1);
    sample(w, ov, ir, s, co, vf);
    chk({tag, ":in_ready"}, {31'd0, ir}, 32'd1);
    @(posedge clk); #1;
    set_iv(w, 1'b0);
    a_t = ~a; b_t = ~b; cin_t = ~ci; sub_t = ~sub;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      sample(w, ov, ir, s, co, vf);
      if (ov) lat = i;
    end
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":sum"}, s, es);
    chk({tag, ":cout"}, {31'd0, co}, {31'd0, ec});
    chk({tag, ":ovf"}, {31'd0, vf}, {31'd0, ev});
    if (ack) begin
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      sample(w, ov, ir, s, co, vf);
      chk({tag, ":ov_drop"}, {31'd0, ov}, 32'd0);
      chk({tag, ":idle"}, {31'd0, ir}, 32'd1);
    end
  endtask

  initial begin
    logic ov, ir, co, vf;
    logic [31:0] s;
    int stray;
    rst = 1'b1; a_t = '0; b_t = '0; cin_t = 1'b0; sub_t = 1'b0; ordy = 1'b0;
    set_iv(0, 1'b0);
    #3;
    sample(16, ov, ir, s, co, vf);
    chk("rst:out_valid", {31'd0, ov}, 32'd0);
    chk("rst:in_ready", {31'd0, ir}, 32'd1);
    chk("rst:sum", s, 32'd0);
    chk("rst:cout_ovf", {30'd0, co, vf}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    do_op("w16_add",   16, 32'h1234, 32'h0FFF, 1'b0, 1'b0, 4, 32'h2233, 1'b0, 1'b0, 1'b1);
    do_op("w16_ripple",16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 4, 32'h0000, 1'b1, 1'b0, 1'b1);
    do_op("w16_cin",   16, 32'h0000, 32'h0000, 1'b1, 1'b0, 4, 32'h0001, 1'b0, 1'b0, 1'b1);
    do_op("w16_sub_ov",16, 32'h8000, 32'h0001, 1'b1, 1'b1, 4, 32'h7FFF, 1'b1, 1'b1, 1'b1);
    do_op("w16_sub_neg",16,32'h0003, 32'h0005, 1'b0, 1'b1, 4, 32'hFFFE, 1'b0, 1'b0, 1'b1);
    do_op("w16_add_ov",16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 4, 32'h8000, 1'b0, 1'b1, 1'b1);

    // Backpressure: result held, new operands offered but not accepted.
    do_op("bp_op", 16, 32'h1111, 32'h2222, 1'b0, 1'b0, 4, 32'h3333, 1'b0, 1'b0, 1'b0);
    a_t = 32'hFFFF; b_t = 32'h0001; cin_t = 1'b1; sub_t = 1'b0;
    iv16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sample(16, ov, ir, s, co, vf);
      chk("bp:out_valid", {31'd0, ov}, 32'd1);
      chk("bp:in_ready", {31'd0, ir}, 32'd0);
      chk("bp:sum", s, 32'h3333);
      chk("bp:flags", {30'd0, co, vf}, 32'd0);
    end
    iv16 = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    sample(16, ov, ir, s, co, vf);
    chk("bp:release_ov", {31'd0, ov}, 32'd0);
    chk("bp:release_rdy", {31'd0, ir}, 32'd1);
    chk("bp:sum_kept", s, 32'h3333);
    do_op("bp_next", 16, 32'h0101, 32'h0202, 1'b0, 1'b0, 4, 32'h0303, 1'b0, 1'b0, 1'b1);

    // Reset after two RUN edges of a full-ripple add.
    a_t = 32'hFFFF; b_t = 32'h0001; cin_t = 1'b0; sub_t = 1'b0;
    iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sample(16, ov, ir, s, co, vf);
    chk("midrst:out_valid", {31'd0, ov}, 32'd0);
    chk("midrst:sum", s, 32'd0);
    chk("midrst:in_ready", {31'd0, ir}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov16) stray++;
    end
    chk("midrst:no_pulse", stray, 0);
    do_op("midrst_next", 16, 32'h0001, 32'h0001, 1'b0, 1'b0, 4, 32'h0002, 1'b0, 1'b0, 1'b1);

    do_op("w4_add",    4, 32'h4, 32'hF, 1'b0, 1'b0, 1, 32'h3, 1'b1, 1'b0, 1'b1);
    do_op("w4_ripple", 4, 32'hF, 32'h1, 1'b0, 1'b0, 1, 32'h0, 1'b1, 1'b0, 1'b1);
    do_op("w4_cin",    4, 32'h0, 32'h0, 1'b1, 1'b0, 1, 32'h1, 1'b0, 1'b0, 1'b1);
    do_op("w32_add",   32, 32'h12341234, 32'h0FFF0FFF, 1'b0, 1'b0, 8, 32'h22332233, 1'b0, 1'b0, 1'b1);
    do_op("w32_ripple",32, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 8, 32'h00000000, 1'b1, 1'b0, 1'b1);
    do_op("w32_cin",   32, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 8, 32'h00000001, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
